// File: rtl/fp32_mant_add_ldz.sv
// fp32_mant_add_ldz: one-stage aligned-mantissa add/subtract with leading-zero count.
// The count is taken combinationally from the same sum that gets registered, so both outputs always agree.
module fp32_mant_add_ldz #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             s_a,
  input  logic             s_b,
  input  logic [WIDTH-1:0] l_shift,
  input  logic [WIDTH-1:0] s_shift,
  output logic             out_valid,
  output logic             xor_o,
  output logic [WIDTH-1:0] adder_1_o,
  output logic [7:0]       ldz_o
);
  logic             op;
  logic [WIDTH-1:0] sum;
  logic [7:0]       lz;
  assign op  = s_a ^ s_b;
  assign sum = op ? l_shift - s_shift : l_shift + s_shift;
  // Ascending scan so the highest set bit wins; an all-zero sum keeps WIDTH.
  always_comb begin
    lz = 8'(WIDTH);
    for (int i = 0; i < WIDTH; i++) lz = sum[i] ? 8'(WIDTH - 1 - i) : lz;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      xor_o     <= 1'b0;
      adder_1_o <= '0;
      ldz_o     <= 8'h00;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        xor_o     <= op;
        adder_1_o <= sum;
        ldz_o     <= lz;
      end
    end
  end
endmodule

// File: tb/tb_fp32_mant_add_ldz.sv
// tb_fp32_mant_add_ldz: reference model plus per-cycle compare and directed literal checks.
module tb_fp32_mant_add_ldz;
  logic        clk = 0, rst_n = 0, in_valid = 0, s_a = 0, s_b = 0;
  logic [47:0] l_shift = '0, s_shift = '0;
  logic        out_valid, xor_o;
  logic [47:0] adder_1_o;
  logic [7:0]  ldz_o;
  int tests = 0, fails = 0;
  logic        m_valid = 0, m_xor = 0;
  logic [47:0] m_sum = '0;
  logic [7:0]  m_lz = 0;

  fp32_mant_add_ldz dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s_a(s_a), .s_b(s_b),
    .l_shift(l_shift), .s_shift(s_shift), .out_valid(out_valid), .xor_o(xor_o),
    .adder_1_o(adder_1_o), .ldz_o(ldz_o));

  always #5 clk = ~clk;

  function automatic logic [7:0] count_lz(input logic [47:0] v);
    int n = 0;
    while (n < 48 && !v[47 - n]) n++;
    return 8'(n);
  endfunction

  function automatic logic [47:0] ref_sum(input logic sub, input logic [47:0] a, input logic [47:0] b);
    longint unsigned r;
    r = sub ? (64'(a) + (64'd1 << 48) - 64'(b)) : (64'(a) + 64'(b));
    return r[47:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_xor = 0; m_sum = '0; m_lz = 0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        m_xor = s_a != s_b;
        m_sum = ref_sum(m_xor, l_shift, s_shift);
        m_lz  = count_lz(m_sum);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("xor_o", 64'(xor_o), 64'(m_xor));
    chk("adder_1_o", 64'(adder_1_o), 64'(m_sum));
    chk("ldz_o", 64'(ldz_o), 64'(m_lz));
  end

  task automatic apply(input logic a, input logic b, input logic [47:0] l, input logic [47:0] s, input logic v);
    @(posedge clk); #1;
    s_a = a; s_b = b; l_shift = l; s_shift = s; in_valid = v;
  endtask

  task automatic settle;
    @(posedge clk); #2;
  endtask

  task automatic lit(input string name, input logic v, input logic x, input logic [47:0] sm, input logic [7:0] lz);
    chk({name, ".valid"}, 64'(out_valid), 64'(v));
    chk({name, ".xor"}, 64'(xor_o), 64'(x));
    chk({name, ".sum"}, 64'(adder_1_o), 64'(sm));
    chk({name, ".ldz"}, 64'(ldz_o), 64'(lz));
    chk({name, ".model_sum"}, 64'(m_sum), 64'(sm));
    chk({name, ".model_ldz"}, 64'(m_lz), 64'(lz));
  endtask

  initial begin
    #1;
    chk("reset.valid", 64'(out_valid), 64'd0);
    chk("reset.sum", 64'(adder_1_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    apply(0, 0, 48'h6487ED800000, 48'h6487ED800000, 1); settle;
    lit("eq_add", 1, 0, 48'hC90FDB000000, 8'd0);
    apply(1, 0, 48'h6487ED800000, 48'h6487ED800000, 1); settle;
    lit("cancel", 1, 1, 48'h0, 8'd48);
    apply(0, 0, 48'h1, 48'h0, 1); settle;
    lit("lsb", 1, 0, 48'h1, 8'd47);
    apply(1, 1, 48'h800000000000, 48'h0, 1); settle;
    lit("msb", 1, 0, 48'h800000000000, 8'd0);
    apply(0, 1, 48'h0, 48'h1, 1); settle;
    lit("wrap", 1, 1, 48'hFFFFFFFFFFFF, 8'd0);
    apply(1, 1, 48'hFFFFFFFFFFFF, 48'h1, 1); settle;
    lit("carry", 1, 0, 48'h0, 8'd48);
    for (int k = 0; k < 48; k++) begin
      apply(0, 0, 48'h1 << k, 48'h0, 1); settle;
      chk($sformatf("onehot%0d", k), 64'(ldz_o), 64'(47 - k));
    end
    apply(0, 1, 48'h000123456789, 48'h000000000009, 1); settle;
    lit("pre_idle", 1, 1, 48'h000123456780, 8'd15);
    apply(1, 1, 48'hFFFF00000000, 48'h1, 0); settle;
    lit("idle", 0, 1, 48'h000123456780, 8'd15);
    for (int i = 0; i < 4; i++) apply(i[0], 0, 48'h10 << (4 * i), 48'h3, 1);
    settle;
    lit("b2b_last", 1, 1, 48'h00000000FFFD, 8'd32);
    #3 rst_n = 0;
    #1;
    chk("async_rst.valid", 64'(out_valid), 64'd0);
    chk("async_rst.xor", 64'(xor_o), 64'd0);
    chk("async_rst.sum", 64'(adder_1_o), 64'd0);
    chk("async_rst.ldz", 64'(ldz_o), 64'd0);
    @(posedge clk); #1 rst_n = 1;
    in_valid = 0;
    settle;
    lit("post_rst_idle", 0, 0, 48'h0, 8'd0);
    for (int i = 0; i < 10000; i++) begin
      logic [47:0] a, b;
      int sh;
      sh = $urandom_range(0, 47);
      a = {$urandom, $urandom} >> sh;
      b = {$urandom, $urandom} >> $urandom_range(0, 47);
      apply(1'($urandom), 1'($urandom), a, b, 1'($urandom_range(0, 7) != 0));
    end
    settle;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
